// File: rtl/turfio_pkg.sv
// Shared definitions for the TURFIO output-lane arbiter: byte width,
// delimiter value and the arbiter state encoding.
package turfio_pkg;

  localparam int TURFIO_BYTE_W = 8;
  localparam logic [TURFIO_BYTE_W-1:0] TURFIO_DELIM_BYTE = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EVT       = 3'd1,
    ST_REG       = 3'd2,
    ST_FLUSH_EVT = 3'd3,
    ST_FLUSH_REG = 3'd4,
    ST_DELIM     = 3'd5
  } arb_state_t;

endpackage

// File: rtl/turfio_pkt_counter.sv
// Up-counter with enable and synchronous clear; SATURATE selects whether it
// sticks at all-ones or wraps to zero.
module turfio_pkt_counter #(
  parameter int W        = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Clear takes priority over a simultaneous count request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !(SATURATE && (cnt == {W{1'b1}}))) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/turfio_dout_arb.sv
// Packet-granular arbiter between event data and register responses onto the
// TURFIO byte lane, with 0x00 framing and clean abort of underrun packets.
module turfio_dout_arb
  import turfio_pkg::*;
#(
  parameter int DELIM_BYTES   = 1,
  parameter int REG_BURST_MAX = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     ifclk_i,
  input  logic                     aresetn,
  input  logic                     enable_i,
  input  logic [TURFIO_BYTE_W-1:0] s_evt_axis_tdata,
  input  logic                     s_evt_axis_tvalid,
  input  logic                     s_evt_axis_tlast,
  output logic                     s_evt_axis_tready,
  input  logic [TURFIO_BYTE_W-1:0] s_reg_axis_tdata,
  input  logic                     s_reg_axis_tvalid,
  input  logic                     s_reg_axis_tlast,
  output logic                     s_reg_axis_tready,
  output logic [TURFIO_BYTE_W-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     underrun_o,
  input  logic                     underrun_clr_i,
  output logic [7:0]               underrun_cnt_o,
  output logic [CNT_WIDTH-1:0]     evt_pkt_cnt_o,
  output logic [CNT_WIDTH-1:0]     reg_pkt_cnt_o,
  output logic                     busy_o
);

  localparam int RUN_W = $clog2(REG_BURST_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(REG_BURST_MAX);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_BYTES - 1);

  arb_state_t       state;
  logic [RUN_W-1:0] run;
  logic [3:0]       delim_cnt;

  logic evt_sel, sel_valid, sel_last, in_pass, in_flush;
  logic pass_hs, underrun, flush_done, grant_reg, grant_evt;
  logic evt_done, reg_done;

  assign evt_sel    = (state == ST_EVT) || (state == ST_FLUSH_EVT);
  assign sel_valid  = evt_sel ? s_evt_axis_tvalid : s_reg_axis_tvalid;
  assign sel_last   = evt_sel ? s_evt_axis_tlast  : s_reg_axis_tlast;
  assign in_pass    = (state == ST_EVT) || (state == ST_REG);
  assign in_flush   = (state == ST_FLUSH_EVT) || (state == ST_FLUSH_REG);
  assign pass_hs    = in_pass && sel_valid && m_axis_tready;
  // The lane wanted a byte the granted source could not supply.
  assign underrun   = in_pass && m_axis_tready && !sel_valid;
  assign flush_done = in_flush && sel_valid && sel_last;
  assign grant_reg  = (state == ST_IDLE) && enable_i && s_reg_axis_tvalid &&
                      ((run < RUN_MAX) || !s_evt_axis_tvalid);
  assign grant_evt  = (state == ST_IDLE) && enable_i && !grant_reg && s_evt_axis_tvalid;
  assign evt_done   = (state == ST_EVT) && pass_hs && sel_last;
  assign reg_done   = (state == ST_REG) && pass_hs && sel_last;

  always_ff @(posedge ifclk_i or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ST_IDLE;
      run       <= '0;
      delim_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_reg) begin
            state <= ST_REG;
            if (run != RUN_MAX) run <= run + RUN_W'(1);
          end else if (grant_evt) begin
            state <= ST_EVT;
            run   <= '0;
          end
        end
        ST_EVT, ST_REG: begin
          if (pass_hs && sel_last) state <= ST_DELIM;
          else if (underrun)       state <= evt_sel ? ST_FLUSH_EVT : ST_FLUSH_REG;
        end
        ST_FLUSH_EVT, ST_FLUSH_REG: begin
          if (flush_done) state <= ST_DELIM;
        end
        ST_DELIM: begin
          if (m_axis_tready) begin
            if (delim_cnt == DELIM_LAST) begin
              state     <= ST_IDLE;
              delim_cnt <= '0;
            end else begin
              delim_cnt <= delim_cnt + 4'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    m_axis_tdata      = TURFIO_DELIM_BYTE;
    m_axis_tvalid     = 1'b0;
    s_evt_axis_tready = 1'b0;
    s_reg_axis_tready = 1'b0;
    case (state)
      ST_EVT: begin
        m_axis_tdata      = s_evt_axis_tdata;
        m_axis_tvalid     = s_evt_axis_tvalid;
        s_evt_axis_tready = m_axis_tready;
      end
      ST_REG: begin
        m_axis_tdata      = s_reg_axis_tdata;
        m_axis_tvalid     = s_reg_axis_tvalid;
        s_reg_axis_tready = m_axis_tready;
      end
      ST_FLUSH_EVT: s_evt_axis_tready = 1'b1;
      ST_FLUSH_REG: s_reg_axis_tready = 1'b1;
      ST_DELIM:     m_axis_tvalid     = 1'b1;
      default: ;
    endcase
  end

  // A clear in the same cycle as a new underrun leaves the flag low.
  always_ff @(posedge ifclk_i or negedge aresetn) begin
    if (!aresetn)            underrun_o <= 1'b0;
    else if (underrun_clr_i) underrun_o <= 1'b0;
    else if (underrun)       underrun_o <= 1'b1;
  end

  assign busy_o = (state != ST_IDLE);

  turfio_pkt_counter #(.W(CNT_WIDTH), .SATURATE(1'b0)) u_evt_cnt (
    .clk(ifclk_i), .rst_n(aresetn), .clr(1'b0), .en(evt_done), .cnt(evt_pkt_cnt_o)
  );

  turfio_pkt_counter #(.W(CNT_WIDTH), .SATURATE(1'b0)) u_reg_cnt (
    .clk(ifclk_i), .rst_n(aresetn), .clr(1'b0), .en(reg_done), .cnt(reg_pkt_cnt_o)
  );

  turfio_pkt_counter #(.W(8), .SATURATE(1'b1)) u_underrun_cnt (
    .clk(ifclk_i), .rst_n(aresetn), .clr(underrun_clr_i), .en(underrun), .cnt(underrun_cnt_o)
  );

endmodule

// File: tb/tb_turfio_dout_arb.sv
// Bench for turfio_dout_arb: queue-fed AXIS sources, lane byte capture, a
// per-cycle vector table for the basic packet and directed corner sequences.
module tb_turfio_dout_arb;

  logic        ifclk_i = 1'b0;
  logic        aresetn;
  logic        enable_i;
  logic [7:0]  s_evt_axis_tdata, s_reg_axis_tdata;
  logic        s_evt_axis_tvalid, s_evt_axis_tlast, s_evt_axis_tready;
  logic        s_reg_axis_tvalid, s_reg_axis_tlast, s_reg_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic        underrun_o, underrun_clr_i;
  logic [7:0]  underrun_cnt_o;
  logic [15:0] evt_pkt_cnt_o, reg_pkt_cnt_o;
  logic        busy_o;

  logic        d3_evt_tready, d3_reg_tready, d3_m_tvalid, d3_underrun, d3_busy;
  logic [7:0]  d3_m_tdata, d3_underrun_cnt;
  logic [15:0] d3_evt_cnt, d3_reg_cnt;

  int checks = 0;
  int errors = 0;

  logic [8:0] evt_q[$];
  logic [8:0] reg_q[$];
  logic [7:0] lane_q[$];
  logic [7:0] lane3_q[$];
  logic [7:0] exp_q[$];
  logic       evt_gap = 1'b0;

  typedef struct {
    logic       tr;
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       busy;
  } vec_t;
  vec_t tbl[12];

  always #5 ifclk_i = ~ifclk_i;

  turfio_dout_arb #(.DELIM_BYTES(1), .REG_BURST_MAX(2), .CNT_WIDTH(16)) dut (
    .ifclk_i(ifclk_i), .aresetn(aresetn), .enable_i(enable_i),
    .s_evt_axis_tdata(s_evt_axis_tdata), .s_evt_axis_tvalid(s_evt_axis_tvalid),
    .s_evt_axis_tlast(s_evt_axis_tlast), .s_evt_axis_tready(s_evt_axis_tready),
    .s_reg_axis_tdata(s_reg_axis_tdata), .s_reg_axis_tvalid(s_reg_axis_tvalid),
    .s_reg_axis_tlast(s_reg_axis_tlast), .s_reg_axis_tready(s_reg_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .underrun_o(underrun_o), .underrun_clr_i(underrun_clr_i), .underrun_cnt_o(underrun_cnt_o),
    .evt_pkt_cnt_o(evt_pkt_cnt_o), .reg_pkt_cnt_o(reg_pkt_cnt_o), .busy_o(busy_o)
  );

  // Second instance shares all inputs; only its delimiter run is checked.
  turfio_dout_arb #(.DELIM_BYTES(3), .REG_BURST_MAX(2), .CNT_WIDTH(16)) dut3 (
    .ifclk_i(ifclk_i), .aresetn(aresetn), .enable_i(enable_i),
    .s_evt_axis_tdata(s_evt_axis_tdata), .s_evt_axis_tvalid(s_evt_axis_tvalid),
    .s_evt_axis_tlast(s_evt_axis_tlast), .s_evt_axis_tready(d3_evt_tready),
    .s_reg_axis_tdata(s_reg_axis_tdata), .s_reg_axis_tvalid(s_reg_axis_tvalid),
    .s_reg_axis_tlast(s_reg_axis_tlast), .s_reg_axis_tready(d3_reg_tready),
    .m_axis_tdata(d3_m_tdata), .m_axis_tvalid(d3_m_tvalid), .m_axis_tready(m_axis_tready),
    .underrun_o(d3_underrun), .underrun_clr_i(underrun_clr_i), .underrun_cnt_o(d3_underrun_cnt),
    .evt_pkt_cnt_o(d3_evt_cnt), .reg_pkt_cnt_o(d3_reg_cnt), .busy_o(d3_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 time unit before the rising edge.
  task automatic applyStimulus(input logic tr);
    logic [8:0] e, r;
    @(negedge ifclk_i);
    e = (evt_q.size() > 0) ? evt_q[0] : 9'h000;
    r = (reg_q.size() > 0) ? reg_q[0] : 9'h000;
    m_axis_tready     = tr;
    s_evt_axis_tvalid = (evt_q.size() > 0) && !evt_gap;
    s_evt_axis_tdata  = e[7:0];
    s_evt_axis_tlast  = e[8];
    s_reg_axis_tvalid = (reg_q.size() > 0);
    s_reg_axis_tdata  = r[7:0];
    s_reg_axis_tlast  = r[8];
    #4;
    if (m_axis_tvalid && m_axis_tready) lane_q.push_back(m_axis_tdata);
    if (d3_m_tvalid && m_axis_tready)   lane3_q.push_back(d3_m_tdata);
    if (s_evt_axis_tvalid && s_evt_axis_tready) void'(evt_q.pop_front());
    if (s_reg_axis_tvalid && s_reg_axis_tready) void'(reg_q.pop_front());
  endtask

  task automatic runUntilIdle(input bit toggle, input int max_cycles);
    int  n = 0;
    bit  ph = 1'b1;
    bit  done;
    do begin
      applyStimulus(toggle ? ph : 1'b1);
      ph = ~ph;
      n++;
      done = !busy_o && (evt_q.size() == 0) && (reg_q.size() == 0);
    end while (!done && n < max_cycles);
    checkOutput("reach_idle", 32'(done), 32'd1);
  endtask

  task automatic checkLane(input string name);
    checkOutput({name, "_len"}, 32'(lane_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < lane_q.size() && i < exp_q.size(); i++)
      checkOutput(name, 32'(lane_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    aresetn = 1'b0; enable_i = 1'b1; underrun_clr_i = 1'b0; m_axis_tready = 1'b0;
    s_evt_axis_tdata = 8'h00; s_evt_axis_tvalid = 1'b0; s_evt_axis_tlast = 1'b0;
    s_reg_axis_tdata = 8'h00; s_reg_axis_tvalid = 1'b0; s_reg_axis_tlast = 1'b0;

    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 8'hA1, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 8'hB2, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 8'hB2, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 8'hD4, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 8'hD4, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (3) @(negedge ifclk_i);
    aresetn = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("rst_evt_tready", 32'(s_evt_axis_tready), 32'd0);
    checkOutput("rst_reg_tready", 32'(s_reg_axis_tready), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_underrun", 32'(underrun_o), 32'd0);
    checkOutput("rst_evt_cnt", 32'(evt_pkt_cnt_o), 32'd0);

    $display("[TB] single event packet, toggling lane ready");
    evt_q = '{9'h0A1, 9'h0B2, 9'h0C3, 9'h1D4};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].tr);
      checkOutput("vec_tvalid", 32'(m_axis_tvalid), 32'(tbl[i].vld));
      checkOutput("vec_tdata", 32'(m_axis_tdata), 32'(tbl[i].data));
      checkOutput("vec_evt_tready", 32'(s_evt_axis_tready), 32'(tbl[i].rdy));
      checkOutput("vec_busy", 32'(busy_o), 32'(tbl[i].busy));
    end
    applyStimulus(1'b1); applyStimulus(1'b0); applyStimulus(1'b1); applyStimulus(1'b0);
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00};
    checkLane("lane_single");
    checkOutput("evt_cnt_single", 32'(evt_pkt_cnt_o), 32'd1);
    lane_q = lane3_q;
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h00, 8'h00, 8'h00};
    checkLane("lane_delim3");
    checkOutput("busy_delim3", 32'(d3_busy), 32'd0);

    $display("[TB] burst-limited grant order");
    lane_q.delete();
    reg_q = '{9'h051, 9'h152, 9'h053, 9'h154, 9'h055, 9'h156, 9'h057, 9'h158};
    evt_q = '{9'h0E1, 9'h1E2, 9'h0E3, 9'h1E4};
    runUntilIdle(1'b1, 300);
    exp_q = '{8'h51, 8'h52, 8'h00, 8'h53, 8'h54, 8'h00, 8'hE1, 8'hE2, 8'h00,
              8'h55, 8'h56, 8'h00, 8'h57, 8'h58, 8'h00, 8'hE3, 8'hE4, 8'h00};
    checkLane("lane_order");
    checkOutput("reg_cnt_order", 32'(reg_pkt_cnt_o), 32'd4);
    checkOutput("evt_cnt_order", 32'(evt_pkt_cnt_o), 32'd3);

    $display("[TB] event underrun mid-packet");
    lane_q.delete();
    evt_q = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h155};
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b1);
    evt_gap = 1'b1;
    applyStimulus(1'b1);
    evt_gap = 1'b0;
    runUntilIdle(1'b0, 50);
    checkOutput("underrun_flag", 32'(underrun_o), 32'd1);
    checkOutput("underrun_cnt", 32'(underrun_cnt_o), 32'd1);
    checkOutput("flush_drained", 32'(evt_q.size()), 32'd0);
    exp_q = '{8'h11, 8'h22, 8'h00};
    checkLane("lane_underrun");
    checkOutput("evt_cnt_underrun", 32'(evt_pkt_cnt_o), 32'd3);
    underrun_clr_i = 1'b1;
    applyStimulus(1'b1);
    underrun_clr_i = 1'b0;
    applyStimulus(1'b1);
    checkOutput("underrun_clr_flag", 32'(underrun_o), 32'd0);
    checkOutput("underrun_clr_cnt", 32'(underrun_cnt_o), 32'd0);

    $display("[TB] 40-cycle training stall");
    lane_q.delete();
    evt_q = '{9'h061, 9'h062, 9'h063, 9'h164};
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b1);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0);
      if (i == 20) begin
        checkOutput("stall_tdata", 32'(m_axis_tdata), 32'h63);
        checkOutput("stall_busy", 32'(busy_o), 32'd1);
      end
    end
    runUntilIdle(1'b0, 50);
    checkOutput("stall_no_underrun", 32'(underrun_o), 32'd0);
    checkOutput("stall_underrun_cnt", 32'(underrun_cnt_o), 32'd0);
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h00};
    checkLane("lane_stall");
    checkOutput("evt_cnt_stall", 32'(evt_pkt_cnt_o), 32'd4);

    $display("[TB] enable dropped mid-packet");
    lane_q.delete();
    evt_q = '{9'h071, 9'h072, 9'h073, 9'h074, 9'h075, 9'h176};
    applyStimulus(1'b1); applyStimulus(1'b1);
    enable_i = 1'b0;
    runUntilIdle(1'b0, 50);
    exp_q = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h00};
    checkLane("lane_disable");
    reg_q = '{9'h0A0, 9'h1A1};
    evt_q = '{9'h0B0, 9'h1B1};
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1);
      checkOutput("disabled_busy", 32'(busy_o), 32'd0);
    end
    checkOutput("disabled_reg_held", 32'(reg_q.size()), 32'd2);
    checkOutput("disabled_evt_held", 32'(evt_q.size()), 32'd2);
    enable_i = 1'b1;
    runUntilIdle(1'b0, 100);
    checkOutput("evt_cnt_enable", 32'(evt_pkt_cnt_o), 32'd6);
    checkOutput("reg_cnt_enable", 32'(reg_pkt_cnt_o), 32'd5);

    $display("[TB] reset during byte 3");
    evt_q = '{9'h081, 9'h082, 9'h083, 9'h084, 9'h185};
    applyStimulus(1'b1); applyStimulus(1'b1); applyStimulus(1'b1);
    @(negedge ifclk_i);
    aresetn = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("mid_rst_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("mid_rst_evt_tready", 32'(s_evt_axis_tready), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);
    checkOutput("mid_rst_evt_cnt", 32'(evt_pkt_cnt_o), 32'd0);
    checkOutput("mid_rst_reg_cnt", 32'(reg_pkt_cnt_o), 32'd0);
    evt_q.delete();
    lane_q.delete();
    applyStimulus(1'b1); applyStimulus(1'b1);
    @(negedge ifclk_i);
    aresetn = 1'b1;
    evt_q = '{9'h091, 9'h192};
    runUntilIdle(1'b1, 50);
    exp_q = '{8'h91, 8'h92, 8'h00};
    checkLane("lane_after_rst");
    checkOutput("evt_cnt_after_rst", 32'(evt_pkt_cnt_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
